logic_unit_pipe: RTL

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit with valid/ready handshake and chained accumulator.
// Optional LOGIC_UNIT_PIPE_STATS_EN adds a 16-bit output-transfer counter (xfer_count).
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             chain,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  output logic [15:0]      xfer_count,
`endif
  output logic             parity
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             xfer_in;
  logic             xfer_out;

  assign in_ready = !valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = valid_q && out_ready;
  assign opb      = chain ? acc_q : b;

  always_comb begin
    res = '0;
    unique case (op)
      3'd0: res = a & opb;
      3'd1: res = a | opb;
      3'd2: res = ~a;
      3'd3: res = ~opb;
      3'd4: res = ~(a & opb);
      3'd5: res = ~(a | opb);
      3'd6: res = a ^ opb;
      3'd7: res = ~(a ^ opb);
      default: res = '0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    zero_d  = zero_q;
    par_d   = par_q;
    acc_d   = acc_q;
    if (xfer_in) begin
      valid_d = 1'b1;
      y_d     = res;
      zero_d  = (res == '0);
      par_d   = ^res;
      acc_d   = res;
    end else if (xfer_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b1;
      par_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      par_q   <= par_d;
      acc_q   <= acc_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = par_q;

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Free-running wrap at 16 bits
  assign cnt_d = xfer_out ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`endif

endmodule
